// File: rtl/ysyx_23060208_mem_arbiter.sv
// Two-master AXI4-Lite arbiter: IFU (master 0, reads only) and EXU
// (master 1, reads or writes) share one memory slave port.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ifu_ar*/ifu_r*        IFU read address / read data channels
//   exu_ar*/exu_r*        EXU read address / read data channels
//   exu_aw*/exu_w*/exu_b* EXU write address / data / response channels
//   m_*                   slave-side AXI4-Lite channels
//   grant                 one-hot owner (bit0 IFU, bit1 EXU), 0 when idle
module ysyx_23060208_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WSTRB_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  ifu_araddr,
    input  logic                   ifu_arvalid,
    output logic                   ifu_arready,
    output logic [DATA_WIDTH-1:0]  ifu_rdata,
    output logic [1:0]             ifu_rresp,
    output logic                   ifu_rvalid,
    input  logic                   ifu_rready,
    input  logic [ADDR_WIDTH-1:0]  exu_araddr,
    input  logic                   exu_arvalid,
    output logic                   exu_arready,
    output logic [DATA_WIDTH-1:0]  exu_rdata,
    output logic [1:0]             exu_rresp,
    output logic                   exu_rvalid,
    input  logic                   exu_rready,
    input  logic [ADDR_WIDTH-1:0]  exu_awaddr,
    input  logic                   exu_awvalid,
    output logic                   exu_awready,
    input  logic [DATA_WIDTH-1:0]  exu_wdata,
    input  logic [WSTRB_WIDTH-1:0] exu_wstrb,
    input  logic                   exu_wvalid,
    output logic                   exu_wready,
    output logic [1:0]             exu_bresp,
    output logic                   exu_bvalid,
    input  logic                   exu_bready,
    output logic [ADDR_WIDTH-1:0]  m_araddr,
    output logic                   m_arvalid,
    input  logic                   m_arready,
    input  logic [DATA_WIDTH-1:0]  m_rdata,
    input  logic [1:0]             m_rresp,
    input  logic                   m_rvalid,
    output logic                   m_rready,
    output logic [ADDR_WIDTH-1:0]  m_awaddr,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [DATA_WIDTH-1:0]  m_wdata,
    output logic [WSTRB_WIDTH-1:0] m_wstrb,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    input  logic [1:0]             m_bresp,
    input  logic                   m_bvalid,
    output logic                   m_bready,
    output logic [1:0]             grant
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IFU_R,
        S_EXU_R,
        S_EXU_W
    } state_t;

    state_t state, state_n;
    logic   last_exu, last_exu_n;
    logic   ifu_req, exu_req, ifu_win;

    assign ifu_req = ifu_arvalid;
    assign exu_req = exu_arvalid | exu_awvalid;
    // On contention the master that did not own the last transaction wins.
    assign ifu_win = ifu_req & (~exu_req | last_exu);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            last_exu <= 1'b1;
        end else begin
            state    <= state_n;
            last_exu <= last_exu_n;
        end
    end

    always_comb begin
        state_n     = state;
        last_exu_n  = last_exu;
        grant       = 2'b00;
        m_araddr    = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awaddr    = '0;
        m_awvalid   = 1'b0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        exu_arready = 1'b0;
        exu_rdata   = '0;
        exu_rresp   = 2'b00;
        exu_rvalid  = 1'b0;
        exu_awready = 1'b0;
        exu_wready  = 1'b0;
        exu_bresp   = 2'b00;
        exu_bvalid  = 1'b0;
        unique case (state)
            S_IDLE: begin
                // A pending store beats a pending load from the EXU.
                if (ifu_win) begin
                    state_n = S_IFU_R;
                end else if (exu_req) begin
                    state_n = exu_awvalid ? S_EXU_W : S_EXU_R;
                end
            end
            S_IFU_R: begin
                grant       = 2'b01;
                m_araddr    = ifu_araddr;
                m_arvalid   = ifu_arvalid;
                ifu_arready = m_arready;
                ifu_rdata   = m_rdata;
                ifu_rresp   = m_rresp;
                ifu_rvalid  = m_rvalid;
                m_rready    = ifu_rready;
                if (m_rvalid && ifu_rready) begin
                    state_n    = S_IDLE;
                    last_exu_n = 1'b0;
                end
            end
            S_EXU_R: begin
                grant       = 2'b10;
                m_araddr    = exu_araddr;
                m_arvalid   = exu_arvalid;
                exu_arready = m_arready;
                exu_rdata   = m_rdata;
                exu_rresp   = m_rresp;
                exu_rvalid  = m_rvalid;
                m_rready    = exu_rready;
                if (m_rvalid && exu_rready) begin
                    state_n    = S_IDLE;
                    last_exu_n = 1'b1;
                end
            end
            S_EXU_W: begin
                grant       = 2'b10;
                m_awaddr    = exu_awaddr;
                m_awvalid   = exu_awvalid;
                exu_awready = m_awready;
                m_wdata     = exu_wdata;
                m_wstrb     = exu_wstrb;
                m_wvalid    = exu_wvalid;
                exu_wready  = m_wready;
                exu_bresp   = m_bresp;
                exu_bvalid  = m_bvalid;
                m_bready    = exu_bready;
                if (m_bvalid && exu_bready) begin
                    state_n    = S_IDLE;
                    last_exu_n = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// Directed bench for the IFU/EXU memory arbiter with a delay-configurable
// AXI4-Lite slave model and scoreboard queues of expected responses.
module tb_ysyx_23060208_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifu_araddr = '0;
    logic        ifu_arvalid = 1'b0;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready = 1'b0;
    logic [31:0] exu_araddr = '0;
    logic        exu_arvalid = 1'b0;
    logic        exu_arready;
    logic [31:0] exu_rdata;
    logic [1:0]  exu_rresp;
    logic        exu_rvalid;
    logic        exu_rready = 1'b0;
    logic [31:0] exu_awaddr = '0;
    logic        exu_awvalid = 1'b0;
    logic        exu_awready;
    logic [31:0] exu_wdata = '0;
    logic [2:0]  exu_wstrb = '0;
    logic        exu_wvalid = 1'b0;
    logic        exu_wready;
    logic [1:0]  exu_bresp;
    logic        exu_bvalid;
    logic        exu_bready = 1'b0;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [2:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [1:0]  grant;

    ysyx_23060208_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_arready(ifu_arready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready),
        .exu_araddr(exu_araddr), .exu_arvalid(exu_arvalid),
        .exu_arready(exu_arready), .exu_rdata(exu_rdata),
        .exu_rresp(exu_rresp), .exu_rvalid(exu_rvalid),
        .exu_rready(exu_rready),
        .exu_awaddr(exu_awaddr), .exu_awvalid(exu_awvalid),
        .exu_awready(exu_awready), .exu_wdata(exu_wdata),
        .exu_wstrb(exu_wstrb), .exu_wvalid(exu_wvalid),
        .exu_wready(exu_wready), .exu_bresp(exu_bresp),
        .exu_bvalid(exu_bvalid), .exu_bready(exu_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave model ----------------
    int         ar_dly = 0, r_dly = 1;
    int         aw_dly = 0, w_dly = 0, b_dly = 1;
    logic [1:0] rresp_cfg = 2'b00;
    logic [1:0] bresp_cfg = 2'b00;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h1357_9BDF);
    endfunction

    logic [31:0] s_raddr = '0;
    logic        s_rbusy = 1'b0;
    int          ar_wait = 0, r_wait = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0;
    logic [2:0]  s_wstrb = '0;
    logic        s_awdone = 1'b0, s_wdone = 1'b0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0;

    assign m_arready = !s_rbusy && (ar_wait >= ar_dly);
    assign m_rvalid  = s_rbusy && (r_wait >= r_dly);
    assign m_rdata   = m_rvalid ? mem_rd(s_raddr) : 32'h0;
    assign m_rresp   = m_rvalid ? rresp_cfg : 2'b00;
    assign m_awready = !s_awdone && (aw_wait >= aw_dly);
    assign m_wready  = !s_wdone && (w_wait >= w_dly);
    assign m_bvalid  = s_awdone && s_wdone && (b_wait >= b_dly);
    assign m_bresp   = m_bvalid ? bresp_cfg : 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            s_rbusy  <= 1'b0;
            ar_wait  <= 0;
            r_wait   <= 0;
            s_awdone <= 1'b0;
            s_wdone  <= 1'b0;
            aw_wait  <= 0;
            w_wait   <= 0;
            b_wait   <= 0;
        end else begin
            if (m_arvalid && m_arready) begin
                s_rbusy <= 1'b1;
                s_raddr <= m_araddr;
                ar_wait <= 0;
                r_wait  <= 0;
            end else if (m_arvalid) begin
                ar_wait <= ar_wait + 1;
            end
            if (s_rbusy) begin
                if (m_rvalid && m_rready) s_rbusy <= 1'b0;
                else if (!m_rvalid) r_wait <= r_wait + 1;
            end
            if (m_awvalid && m_awready) begin
                s_awdone <= 1'b1;
                s_awaddr <= m_awaddr;
                aw_wait  <= 0;
            end else if (m_awvalid && !s_awdone) begin
                aw_wait <= aw_wait + 1;
            end
            if (m_wvalid && m_wready) begin
                s_wdone <= 1'b1;
                s_wdata <= m_wdata;
                s_wstrb <= m_wstrb;
                w_wait  <= 0;
            end else if (m_wvalid && !s_wdone) begin
                w_wait <= w_wait + 1;
            end
            if (s_awdone && s_wdone) begin
                if (m_bvalid && m_bready) begin
                    s_awdone <= 1'b0;
                    s_wdone  <= 1'b0;
                    b_wait   <= 0;
                end else if (!m_bvalid) begin
                    b_wait <= b_wait + 1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
    } rexp_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  s;
        logic [1:0]  r;
    } wexp_t;
    typedef struct packed {
        logic [1:0] g;
        int         c;
    } gst_t;

    rexp_t ifq[$];
    rexp_t exq[$];
    wexp_t wq[$];
    gst_t  st_q[$];
    int    en_q[$];
    logic [1:0] prev_g = 2'b00;

    logic any_out, ifu_outs, exu_outs;
    assign any_out = |{ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid,
                       exu_arready, exu_rdata, exu_rresp, exu_rvalid,
                       exu_awready, exu_wready, exu_bresp, exu_bvalid,
                       m_araddr, m_arvalid, m_rready, m_awaddr, m_awvalid,
                       m_wdata, m_wstrb, m_wvalid, m_bready, grant};
    assign ifu_outs = |{ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid};
    assign exu_outs = |{exu_arready, exu_rdata, exu_rresp, exu_rvalid,
                        exu_awready, exu_wready, exu_bresp, exu_bvalid,
                        m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid,
                        m_bready};

    // Per-cycle isolation checks and a log of grant start/end cycles.
    always @(negedge clk) begin
        #2;
        if (cyc > 0) begin
            if (grant === 2'b00) begin
                chk("idle_zero", any_out, 1'b0);
                chk("slv_resp_idle", m_rvalid | m_bvalid, 1'b0);
            end else if (grant === 2'b01) begin
                chk("ifu_own_iso", exu_outs, 1'b0);
            end else if (grant === 2'b10) begin
                chk("exu_own_iso", ifu_outs, 1'b0);
            end else begin
                chk("grant_legal", grant, 2'b00);
            end
            if (grant !== 2'b00 && prev_g === 2'b00)
                st_q.push_back('{g: grant, c: cyc});
            if (grant === 2'b00 && prev_g !== 2'b00)
                en_q.push_back(cyc);
        end
        prev_g <= grant;
    end

    // ---------------- master tasks ----------------
    task automatic ifu_read(input logic [31:0] a);
        bit    r_p, ar_h, r_h;
        int    n;
        rexp_t e;
        ifq.push_back('{d: mem_rd(a), r: rresp_cfg});
        ifu_araddr  = a;
        ifu_arvalid = 1'b1;
        ifu_rready  = 1'b1;
        r_p = 1'b1;
        n = 0;
        while (r_p && n < 200) begin
            #1;
            ar_h = ifu_arvalid && (ifu_arready === 1'b1);
            r_h  = ifu_rready && (ifu_rvalid === 1'b1);
            if (r_h) begin
                e = ifq.pop_front();
                chk("ifu_rdata", ifu_rdata, e.d);
                chk("ifu_rresp", ifu_rresp, e.r);
                chk("ifu_r_grant", grant, 2'b01);
            end
            @(negedge clk);
            n++;
            if (ar_h) ifu_arvalid = 1'b0;
            if (r_h) begin
                ifu_rready = 1'b0;
                r_p = 1'b0;
            end
        end
        if (r_p) begin
            chk("ifu_timeout", 1'b1, 1'b0);
            void'(ifq.pop_front());
            ifu_arvalid = 1'b0;
            ifu_rready  = 1'b0;
        end else begin
            chk("ifu_idle_after", grant, 2'b00);
        end
    endtask

    task automatic exu_txn(input bit do_w, input bit do_r,
                           input logic [31:0] waddr,
                           input logic [31:0] wdata,
                           input logic [2:0]  wstrb,
                           input logic [31:0] raddr);
        bit    b_p, r_p, aw_h, w_h, b_h, ar_h, r_h;
        int    n;
        rexp_t e;
        wexp_t we;
        if (do_w) wq.push_back('{a: waddr, d: wdata, s: wstrb, r: bresp_cfg});
        if (do_r) exq.push_back('{d: mem_rd(raddr), r: rresp_cfg});
        exu_awaddr  = waddr;
        exu_awvalid = do_w;
        exu_wdata   = wdata;
        exu_wstrb   = wstrb;
        exu_wvalid  = do_w;
        exu_bready  = do_w;
        exu_araddr  = raddr;
        exu_arvalid = do_r;
        exu_rready  = do_r;
        b_p = do_w;
        r_p = do_r;
        n = 0;
        while ((b_p || r_p) && n < 200) begin
            #1;
            aw_h = exu_awvalid && (exu_awready === 1'b1);
            w_h  = exu_wvalid && (exu_wready === 1'b1);
            b_h  = exu_bready && (exu_bvalid === 1'b1);
            ar_h = exu_arvalid && (exu_arready === 1'b1);
            r_h  = exu_rready && (exu_rvalid === 1'b1);
            if (b_p && do_r)
                chk("exu_ar_blocked", exu_arready, 1'b0);
            if (b_h) begin
                we = wq.pop_front();
                chk("exu_bresp", exu_bresp, we.r);
                chk("slv_awaddr", s_awaddr, we.a);
                chk("slv_wdata", s_wdata, we.d);
                chk("slv_wstrb", s_wstrb, we.s);
                chk("exu_b_grant", grant, 2'b10);
            end
            if (r_h) begin
                e = exq.pop_front();
                chk("exu_rdata", exu_rdata, e.d);
                chk("exu_rresp", exu_rresp, e.r);
                chk("exu_r_grant", grant, 2'b10);
            end
            @(negedge clk);
            n++;
            if (aw_h) exu_awvalid = 1'b0;
            if (w_h) exu_wvalid = 1'b0;
            if (ar_h) exu_arvalid = 1'b0;
            if (b_h) begin
                exu_bready = 1'b0;
                b_p = 1'b0;
            end
            if (r_h) begin
                exu_rready = 1'b0;
                r_p = 1'b0;
            end
        end
        if (b_p || r_p) begin
            chk("exu_timeout", 1'b1, 1'b0);
            wq.delete();
            exq.delete();
            exu_awvalid = 1'b0;
            exu_wvalid  = 1'b0;
            exu_bready  = 1'b0;
            exu_arvalid = 1'b0;
            exu_rready  = 1'b0;
        end else begin
            chk("exu_idle_after", grant, 2'b00);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        ifu_arvalid = 1'b0;
        ifu_rready  = 1'b0;
        exu_arvalid = 1'b0;
        exu_rready  = 1'b0;
        exu_awvalid = 1'b0;
        exu_wvalid  = 1'b0;
        exu_bready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_order(input string tag, input logic [1:0] g0,
                             input logic [1:0] g1);
        chk({tag, "_cnt"}, st_q.size(), 2);
        if (st_q.size() >= 2 && en_q.size() >= 1) begin
            chk({tag, "_first"}, st_q[0].g, g0);
            chk({tag, "_second"}, st_q[1].g, g1);
            chk({tag, "_gap"}, st_q[1].c - en_q[0], 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic       exp_last_exu;
        logic [1:0] exp_own;
        logic [31:0] a;
        bit         hs;
        int         n;

        reset_dut();
        #1;
        chk("reset_grant", grant, 2'b00);
        chk("reset_outs", any_out, 1'b0);

        // Lone IFU fetch; checks one-cycle grant latency on the way.
        @(negedge clk);
        r_dly = 2;
        fork
            ifu_read(32'h8000_0000);
            begin
                #1;
                chk("lat_idle_grant", grant, 2'b00);
                @(negedge clk);
                #1;
                chk("lat_grant", grant, 2'b01);
                chk("lat_m_arvalid", m_arvalid, 1'b1);
                chk("lat_m_araddr", m_araddr, 32'h8000_0000);
            end
        join
        r_dly = 1;

        // Store with a stalled IFU; IFU owned last, so the EXU wins.
        @(negedge clk);
        st_q.delete();
        en_q.delete();
        aw_dly = 3;
        w_dly  = 1;
        b_dly  = 2;
        fork
            exu_txn(1'b1, 1'b0, 32'h8000_1000, 32'hDEAD_BEEF,
                    3'b100, 32'h0);
            ifu_read(32'h8000_0040);
        join
        #3;
        chk_order("st", 2'b10, 2'b01);
        aw_dly = 0;
        w_dly  = 0;
        b_dly  = 1;

        // Continuous contention after reset: owners must alternate.
        reset_dut();
        @(negedge clk);
        st_q.delete();
        en_q.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    a = 32'h8000_0100 + 32'(i * 4);
                    ifu_read(a);
                end
            end
            begin
                for (int j = 0; j < 4; j++) begin
                    exu_txn(1'b0, 1'b1, 32'h0, 32'h0, 3'b000,
                            32'h8000_2000 + 32'(j * 4));
                end
            end
        join
        #3;
        chk("rr_cnt", st_q.size(), 8);
        exp_last_exu = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_own = exp_last_exu ? 2'b01 : 2'b10;
            exp_last_exu = (exp_own == 2'b10);
            if (k < st_q.size()) chk("rr_owner", st_q[k].g, exp_own);
            if (k < 7 && k + 1 < st_q.size() && k < en_q.size())
                chk("rr_gap", st_q[k+1].c - en_q[k], 1);
        end

        // EXU presents AW and AR together: write first, then the read.
        @(negedge clk);
        st_q.delete();
        en_q.delete();
        exu_txn(1'b1, 1'b1, 32'h8000_1100, 32'h1234_5678,
                3'b010, 32'h8000_1200);
        #3;
        chk_order("awar", 2'b10, 2'b10);

        // SLVERR on an EXU load is forwarded untouched.
        @(negedge clk);
        rresp_cfg = 2'b10;
        exu_txn(1'b0, 1'b1, 32'h0, 32'h0, 3'b000, 32'h8000_3000);
        rresp_cfg = 2'b00;
        ifu_read(32'h8000_0000);

        // Reset in the middle of a write, after the AW handshake.
        aw_dly = 0;
        w_dly  = 5;
        b_dly  = 0;
        exu_awaddr  = 32'h8000_4000;
        exu_awvalid = 1'b1;
        exu_wdata   = 32'hCAFE_F00D;
        exu_wstrb   = 3'b001;
        exu_wvalid  = 1'b1;
        exu_bready  = 1'b1;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 50) begin
            #1;
            hs = (exu_awready === 1'b1);
            @(negedge clk);
            n++;
        end
        if (!hs) chk("rst_aw_timeout", 1'b1, 1'b0);
        exu_awvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_pre_grant", grant, 2'b10);
        @(negedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_outs", any_out, 1'b0);
        exu_wvalid = 1'b0;
        exu_bready = 1'b0;
        w_dly = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        ifu_read(32'h8000_0080);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_mem_arbiter.md
Name: ysyx_23060208_mem_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter sharing the single memory port between the IFU and the EXU.
- IFU is master 0 and issues reads only (instruction fetch).
- EXU is master 1 and issues reads (loads) or writes (stores).
- Grants one whole transaction at a time, round-robin between masters, and holds the grant until the response handshake completes.

Parameters:
- ADDR_WIDTH, 32, address width on all AR/AW channels
- DATA_WIDTH, 32, data width on R/W channels
- WSTRB_WIDTH, 3, store-size code width; passed through unchanged

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_araddr  in  ADDR_WIDTH  IFU read address
- ifu_arvalid  in  1  IFU read request valid
- ifu_arready  out  1  IFU AR ready
- ifu_rdata  out  DATA_WIDTH  IFU read data
- ifu_rresp  out  2  IFU read response
- ifu_rvalid  out  1  IFU R valid
- ifu_rready  in  1  IFU R ready
- exu_araddr  in  ADDR_WIDTH  EXU read address
- exu_arvalid  in  1  EXU read request valid
- exu_arready  out  1  EXU AR ready
- exu_rdata  out  DATA_WIDTH  EXU read data
- exu_rresp  out  2  EXU read response
- exu_rvalid  out  1  EXU R valid
- exu_rready  in  1  EXU R ready
- exu_awaddr  in  ADDR_WIDTH  EXU write address
- exu_awvalid  in  1  EXU AW valid
- exu_awready  out  1  EXU AW ready
- exu_wdata  in  DATA_WIDTH  EXU write data
- exu_wstrb  in  WSTRB_WIDTH  EXU write size code
- exu_wvalid  in  1  EXU W valid
- exu_wready  out  1  EXU W ready
- exu_bresp  out  2  EXU write response
- exu_bvalid  out  1  EXU B valid
- exu_bready  in  1  EXU B ready
- m_araddr, m_arvalid, m_arready, m_rdata, m_rresp, m_rvalid, m_rready, m_awaddr, m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, m_wready, m_bresp, m_bvalid, m_bready  (slave-side AXI4-Lite; mirror directions and widths of the above)
- grant  out  2  one-hot current owner; bit0 = IFU, bit1 = EXU; 0 when idle

Behaviour:
- Reset: state IDLE, grant = 0, last_owner = EXU (IFU wins first contention). Reset overrides everything, including mid-transaction; the slave is reset by the same rst.
- Idle outputs: all outputs toward the slave and masters are 0 whenever the channel is not granted, including all valids, readies and data.
- States:
  - IDLE: sample requests. ifu_req = ifu_arvalid; exu_req = exu_arvalid | exu_awvalid.
    - Only one requests -> grant it.
    - Both request -> grant the master that is not last_owner.
    - IFU wins -> S_IFU_R.
    - EXU wins with exu_awvalid=1 -> S_EXU_W.
    - EXU wins with exu_awvalid=0 -> S_EXU_R.
    - If EXU asserts both AW and AR, the write wins; the read stays pending.
  - S_IFU_R: AR and R channels connected combinationally, slave <-> IFU. Leave when m_rvalid && ifu_rready -> IDLE, last_owner = IFU.
  - S_EXU_R: same connection for the EXU. Leave when m_rvalid && exu_rready -> IDLE, last_owner = EXU.
  - S_EXU_W: AW, W and B channels connected combinationally to the EXU. AW and W pass through independently, in either order. Leave when m_bvalid && exu_bready -> IDLE, last_owner = EXU.
- Grant latency: a request first visible in cycle N (state IDLE) is granted in N+1; the slave sees its valid in N+1. Data and response paths add zero cycles.
- Back-to-back: exactly one IDLE cycle separates consecutive transactions.
- grant reflects the state: S_IFU_R -> 01; S_EXU_* -> 10; IDLE -> 00.
- Valid-hold rule: masters must hold valid until ready. The losing master's request stays pending, with its arready at 0, until it is granted.
- Response codes rresp/bresp are forwarded unchanged; SLVERR does not alter the FSM.
- A slave response arriving in IDLE, or on the channel not owned, is not acknowledged (ready=0). This is a protocol error; a bench assertion flags it.
- No timeout. A slave that never responds holds the grant indefinitely.

Test Plan:
- Lone IFU read at 0x80000000: slave arready=1, rvalid two cycles later with rdata=0x00000413 -> IFU receives 0x00000413 and rresp=0; grant 01 for the transaction and 00 one cycle after the R handshake.
- IFU and EXU read in the same cycle after reset -> IFU served first, EXU next after one IDLE cycle; repeat the contention -> EXU wins (alternation verified over 8 rounds).
- EXU store: awaddr=0x80001000, wdata=0xDEADBEEF, wstrb=3'b100, slave awready delayed 3 cycles, wready delayed 1, bvalid 2 cycles later -> slave sees exact address, data and strobe; EXU gets bvalid, bresp=0; IFU arvalid held throughout stays stalled with arready=0, then is served.
- EXU asserts AW and AR together -> write completes first, read granted after one IDLE cycle.
- Slave returns rresp=2'b10 to the EXU -> forwarded as 2'b10; FSM returns to IDLE normally.
- rst asserted in S_EXU_W after the AW handshake -> next cycle all outputs 0, grant 00; after rst drops, a fresh IFU read completes correctly.
